// File: rtl/mem_line_responder.sv
// Fixed-latency line-fill / write-through memory responder for the L1 caches.
// A read returns a whole line critical-word-first; a write returns one empty pulse.
module mem_line_responder #(
  parameter int unsigned WORDS     = 4,
  parameter int unsigned LAT       = 20,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        busy
);

  localparam int unsigned OFFW = $clog2(WORDS);
  localparam int unsigned CNTW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD  = CNTW'(LAT - 1);
  localparam logic [OFFW-1:0] BEAT_LAST = OFFW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WDONE} state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [OFFW-1:0]      beat_q, beat_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 write_q, write_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [31:0]          mem [0:(1<<ADDR_BITS)-1];

  logic                 accept;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [31:0]          mem_wdata;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS-1:0] req_idx;
  logic [OFFW-1:0]      nxt_off;
  logic                 unused_addr_bits;

  assign req_idx          = req_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};
  assign accept           = req_valid & req_ready;
  // Offset arithmetic is OFFW bits wide, so the burst wraps inside its line.
  assign nxt_off          = idx_q[OFFW-1:0] + beat_q + OFFW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = wdata_q;
    rd_en     = 1'b0;
    rd_addr   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = req_idx;
          write_d = req_write;
          wdata_d = req_wdata;
          beat_d  = '0;
          if (LAT == 1) begin
            if (req_write) begin
              state_d   = S_WDONE;
              mem_we    = 1'b1;
              mem_waddr = req_idx;
              mem_wdata = req_wdata;
            end else begin
              state_d = S_BURST;
              rd_en   = 1'b1;
              rd_addr = req_idx;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d = S_WDONE;
            mem_we  = 1'b1;
          end else begin
            state_d = S_BURST;
            beat_d  = '0;
            rd_en   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_BURST: begin
        if (beat_q == BEAT_LAST) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + OFFW'(1);
          rd_en   = 1'b1;
          rd_addr = {idx_q[ADDR_BITS-1:OFFW], nxt_off};
        end
      end
      S_WDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdata_d = rd_en ? mem[rd_addr] : '0;
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) && reset;
    resp_valid = (state_q == S_BURST) || (state_q == S_WDONE);
    resp_last  = ((state_q == S_BURST) && (beat_q == BEAT_LAST)) || (state_q == S_WDONE);
    resp_rdata = (state_q == S_BURST) ? rdata_q : '0;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: instance 0 uses defaults, instance 1 uses LAT=1, WORDS=8.
// Expected beats come from a word-array model indexed with wrap-around arithmetic.
module tb_mem_line_responder;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, req_valid, req_ready, req_write, resp_valid, resp_last, busy;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [31:0] ref_mem [2][1024];
  int unsigned wds [2] = '{4, 8};
  int unsigned lat [2] = '{20, 1};

  always #5 clk = ~clk;

  mem_line_responder #(.WORDS(4), .LAT(20), .ADDR_BITS(10)) dut0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_last(resp_last[0]),
    .busy(busy[0])
  );

  mem_line_responder #(.WORDS(8), .LAT(1), .ADDR_BITS(10)) dut1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_last(resp_last[1]),
    .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk_addr(input int unsigned idx);
    logic [31:0] a;
    a       = $urandom;
    a[11:2] = idx[9:0];
    return a;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    n = 0;
    req_write[s] = w; req_addr[s] = a; req_wdata[s] = d; req_valid[s] = 1'b1;
    while (!req_ready[s] && n < 500) begin @(posedge clk); #1; n++; end
    check("accept_wait", 32'(n < 500), 32'd1);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_first(input int s);
    int unsigned n;
    n = 0;
    while (!resp_valid[s] && n < 300) begin @(posedge clk); #1; n++; end
    check("first_latency", n, (lat[s] == 1) ? 32'd0 : lat[s]);
  endtask

  task automatic do_read(input int s, input logic [31:0] addr);
    int unsigned idx, w, off, base;
    issue(s, 1'b0, addr, $urandom);
    wait_first(s);
    idx = 32'(addr[11:2]); w = wds[s]; off = idx % w; base = idx - off;
    for (int unsigned k = 0; k < w; k++) begin
      check("beat_valid", 32'(resp_valid[s]), 32'd1);
      check("beat_data", resp_rdata[s], ref_mem[s][base + (off + k) % w]);
      check("beat_last", 32'(resp_last[s]), 32'(k == w - 1));
      @(posedge clk); #1;
    end
    check("read_end_valid", 32'(resp_valid[s]), 32'd0);
    check("read_end_ready", 32'(req_ready[s]), 32'd1);
  endtask

  task automatic do_write(input int s, input logic [31:0] addr, input logic [31:0] data);
    issue(s, 1'b1, addr, data);
    wait_first(s);
    check("wdone_valid", 32'(resp_valid[s]), 32'd1);
    check("wdone_last", 32'(resp_last[s]), 32'd1);
    check("wdone_rdata", resp_rdata[s], 32'd0);
    ref_mem[s][addr[11:2]] = data;
    @(posedge clk); #1;
    check("write_end_valid", 32'(resp_valid[s]), 32'd0);
    check("write_end_ready", 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc_n, acc_first, acc_last, ready_busy, n;
    rst_n = '0; req_valid = '0; req_write = '0;
    for (int s = 0; s < 2; s++) begin req_addr[s] = '0; req_wdata[s] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(req_ready[s]), 32'd0);
      check("rst_valid", 32'(resp_valid[s]), 32'd0);
      check("rst_last", 32'(resp_last[s]), 32'd0);
      check("rst_rdata", resp_rdata[s], 32'd0);
      check("rst_busy", 32'(busy[s]), 32'd0);
    end
    @(negedge clk); rst_n = '1;
    @(posedge clk); #1;
    check("post_rst_ready0", 32'(req_ready[0]), 32'd1);
    check("post_rst_ready1", 32'(req_ready[1]), 32'd1);

    // Line fill, in-order and wrapped
    for (int unsigned i = 0; i < 4; i++) do_write(0, 32'h40 + 4 * i, 32'hA0 + i);
    do_read(0, 32'h40);
    do_read(0, 32'h48);
    do_write(0, 32'h100, 32'hDEADBEEF);
    do_read(0, 32'h100);

    // req_valid held: one accept per transaction, separated by one idle cycle
    acc_n = 0; acc_first = 0; acc_last = 0; ready_busy = 0;
    req_write[0] = 1'b0; req_addr[0] = 32'h40; req_valid[0] = 1'b1;
    for (int unsigned c = 0; c < 60; c++) begin
      if (req_ready[0] && busy[0]) ready_busy++;
      if (req_ready[0]) begin
        if (acc_n == 0) acc_first = c;
        acc_last = c;
        acc_n++;
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    check("hold_accepts", acc_n, 32'd3);
    check("hold_spacing", acc_last - acc_first, 2 * (lat[0] + wds[0] + 1));
    check("hold_ready_busy", ready_busy, 32'd0);
    n = 0;
    while (busy[0] && n < 100) begin @(posedge clk); #1; n++; end
    check("hold_drain", 32'(busy[0]), 32'd0);

    // Asynchronous reset during beat 2 of a read
    issue(0, 1'b0, 32'h40, 32'h0);
    wait_first(0);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_beat2", resp_rdata[0], ref_mem[0][18]);
    #2 rst_n[0] = 1'b0;
    #1;
    check("abort_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_rdata", resp_rdata[0], 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk); rst_n[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_no_beats", 32'(resp_valid[0]), 32'd0);
    check("abort_ready_back", 32'(req_ready[0]), 32'd1);

    // Asynchronous reset during WAIT of a write: memory must keep the old word
    issue(0, 1'b1, 32'h44, 32'h5555AAAA);
    repeat (5) begin @(posedge clk); #1; end
    check("wabort_busy_before", 32'(busy[0]), 32'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("wabort_busy", 32'(busy[0]), 32'd0);
    @(negedge clk); rst_n[0] = 1'b1;
    @(posedge clk); #1;
    do_read(0, 32'h40);

    // LAT=1, WORDS=8: wrap from the last word of the line
    for (int unsigned i = 0; i < 8; i++) do_write(1, 4 * i, 32'h700 + i);
    do_read(1, 32'h1C);
    do_read(1, 32'h08);

    // Randomised traffic with aliased upper address bits
    for (int unsigned i = 0; i < 64; i++) do_write(0, mk_addr(i), $urandom);
    for (int unsigned i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_write(0, mk_addr($urandom_range(0, 63)), $urandom);
      else do_read(0, mk_addr($urandom_range(0, 63)));
    end
    for (int unsigned i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) do_write(1, mk_addr($urandom_range(0, 7)), $urandom);
      else do_read(1, mk_addr($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Main-memory side of the cache refill/write-through interface: the responder that answers the data cache's line-fill and single-word write requests.
- Models a fixed-latency DRAM. Accepts one request at a time, waits a programmable first-word latency, then returns a full line as a burst, one word per cycle, critical word first.
- Sits below the L1 caches in the pipelined MIPS core. Serves as both the bench memory and the synthesisable memory model.

Parameters:
- WORDS, 4, words per cache line; power of two, 2..16.
- LAT, 20, cycles from request acceptance to first response word; minimum 1.
- ADDR_BITS, 10, log2 of memory depth in 32-bit words.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = single-word write, 0 = line read.
- req_addr  input  32  byte address. Bits [1:0] are ignored.
- req_wdata  input  32  write data; used only when req_write=1.
- resp_valid  output  1  resp_rdata is valid this cycle.
- resp_rdata  output  32  read data word.
- resp_last  output  1  final beat of the current response.
- busy  output  1  a request is outstanding (state is not IDLE).

Behaviour:
- Handshake:
  - A request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE. One request is outstanding at most.
  - There is no response backpressure: the requester must always sink beats.
- Accept-time latching: req_write, req_wdata and the word index idx=req_addr[ADDR_BITS+1:2] are latched at the accepting edge. Address bits above ADDR_BITS+1 are ignored (aliasing).
- FSM states: IDLE, WAIT, BURST, WDONE.
  - IDLE -> WAIT on accept. The latency counter loads LAT-1.
  - WAIT: the counter decrements each cycle. At 0, go to BURST (read) or WDONE (write).
  - BURST: lasts exactly WORDS cycles. Go to IDLE after the beat with resp_last=1.
  - WDONE: lasts one cycle, then IDLE.
- Timing: with acceptance at edge E, the first beat (or WDONE) is valid in the cycle following edge E+LAT.
  - LAT=1: skip WAIT entirely. The first beat appears in the cycle immediately after the accepting edge.
- Read burst, critical word first:
  - Beat k (k = 0..WORDS-1) returns mem[{line_base, (off+k) mod WORDS}].
  - off = idx[log2(WORDS)-1:0]; line_base = the remaining upper index bits.
  - The offset wraps inside the line and never crosses into the neighbouring line.
- resp_last: 1 on beat WORDS-1 and in WDONE; 0 otherwise.
- resp_valid: 1 exactly in BURST and WDONE cycles.
- resp_rdata:
  - In BURST it comes from a registered read, so data is stable for the whole beat.
  - In WDONE and all non-valid cycles it is 0.
- Write:
  - The memory array is updated at the edge that enters WDONE.
  - A read accepted afterwards returns the new value.
  - A write never produces read data.
- Reset (reset=0, asynchronous):
  - State returns to IDLE; counters clear.
  - req_ready=0 while reset is asserted, then 1 after deassertion.
  - resp_valid=0, resp_last=0, resp_rdata=0, busy=0.
- Reset mid-operation:
  - An in-progress burst is aborted immediately, with no further beats.
  - A pending write is discarded and memory is unmodified.
  - The memory array itself is not cleared by reset; contents before the first write are undefined.
- Simultaneous events:
  - A req_valid held high during busy is ignored and not queued.
  - A new request can be accepted on the edge that follows the last beat, because state has returned to IDLE and req_ready=1.

Test Plan:
- Default parameters. Write 0xA0..0xA3 to byte addresses 0x40..0x4C, then read 0x40. Required: 4 beats A0,A1,A2,A3 in consecutive cycles; resp_last on the 4th; first beat 20 cycles after acceptance.
- Same memory, read address 0x48. Required: critical-word-first wrap A2,A3,A0,A1; no access to 0x50.
- Write 0xDEADBEEF to 0x100. Required: single resp_valid/resp_last pulse with rdata=0 at E+LAT. A following read of 0x100 returns 0xDEADBEEF as beat 0.
- Hold req_valid=1 continuously. Required: req_ready low during WAIT/BURST; exactly one acceptance per transaction; back-to-back transactions separated only by the IDLE cycle.
- Assert reset=0 asynchronously during beat 2 of a read, and again during WAIT of a write. Required: resp_valid drops without waiting for a clock edge; state is IDLE; the written address retains its old value.
- LAT=1, WORDS=8. Read 0x1C. Required: beat 0 in the cycle after acceptance; order words 7,0,1,...,6; resp_last on the 8th beat.
